// File: rtl/clock_time_counter.sv
// Hours/minutes/seconds timekeeper with a RUN/SET controller for user time-set buttons.
// Fields are binary; o_time_stb pulses the cycle after any field changes.
module clock_time_counter #(
    parameter int TWELVE_HOUR = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_en,
    input  logic       i_1hz_stb,
    input  logic       i_timeset_stb,
    input  logic       i_set_hours,
    input  logic       i_set_minutes,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic       o_setting,
    output logic       o_time_stb
);

    // state | meaning
    // RUN   | seconds advance on the 1 Hz strobe with full carry chain
    // SET   | seconds held at 0; selected fields step on the time-set strobe
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_SET = 1'b1;

    localparam logic [4:0] HOUR_MIN = (TWELVE_HOUR != 0) ? 5'd1  : 5'd0;
    localparam logic [4:0] HOUR_MAX = (TWELVE_HOUR != 0) ? 5'd12 : 5'd23;
    localparam logic [4:0] HOUR_RST = (TWELVE_HOUR != 0) ? 5'd12 : 5'd0;

    logic [0:0] state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       time_stb_q, time_stb_d;
    logic       set_req;

    // ">=" limits so a corrupted field wraps to its minimum
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h >= HOUR_MAX) ? HOUR_MIN : h + 5'd1;
    endfunction

    function automatic logic [5:0] next_sixty(input logic [5:0] v);
        return (v >= 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    assign set_req = i_set_hours | i_set_minutes;

    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        time_stb_d = 1'b0;
        if (i_en) begin
            case (state_q)
                ST_RUN: begin
                    if (set_req) begin
                        state_d    = ST_SET;
                        seconds_d  = 6'd0;
                        time_stb_d = 1'b1;
                        if (i_set_hours)   hours_d   = next_hour(hours_q);
                        if (i_set_minutes) minutes_d = next_sixty(minutes_q);
                    end else if (i_1hz_stb) begin
                        seconds_d  = next_sixty(seconds_q);
                        time_stb_d = 1'b1;
                        if (seconds_q >= 6'd59) begin
                            minutes_d = next_sixty(minutes_q);
                            if (minutes_q >= 6'd59) hours_d = next_hour(hours_q);
                        end
                    end
                end
                ST_SET: begin
                    seconds_d = 6'd0;
                    if (!set_req) begin
                        state_d = ST_RUN;
                    end else if (i_timeset_stb) begin
                        // set increments never carry between fields
                        time_stb_d = 1'b1;
                        if (i_set_hours)   hours_d   = next_hour(hours_q);
                        if (i_set_minutes) minutes_d = next_sixty(minutes_q);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_RUN;
            hours_q    <= HOUR_RST;
            minutes_q  <= 6'd0;
            seconds_q  <= 6'd0;
            time_stb_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            time_stb_q <= time_stb_d;
        end
    end

    assign o_hours    = hours_q;
    assign o_minutes  = minutes_q;
    assign o_seconds  = seconds_q;
    assign o_setting  = (state_q == ST_SET);
    assign o_time_stb = time_stb_q;

endmodule

// File: tb/tb_clock_time_counter.sv
// Bench for clock_time_counter: 24 h and 12 h instances share stimulus and are
// checked against a seconds-of-day reference model plus directed constants.
module tb_clock_time_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0, hz = 1'b0, ts = 1'b0, sh = 1'b0, sm = 1'b0;
    logic [4:0] hr0, hr1;
    logic [5:0] mi0, mi1, se0, se1;
    logic       st0, st1, stb0, stb1;

    always #5 clk = ~clk;

    clock_time_counter #(.TWELVE_HOUR(0)) u24 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_timeset_stb(ts),
        .i_set_hours(sh), .i_set_minutes(sm),
        .o_hours(hr0), .o_minutes(mi0), .o_seconds(se0), .o_setting(st0), .o_time_stb(stb0)
    );

    clock_time_counter #(.TWELVE_HOUR(1)) u12 (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_1hz_stb(hz), .i_timeset_stb(ts),
        .i_set_hours(sh), .i_set_minutes(sm),
        .o_hours(hr1), .o_minutes(mi1), .o_seconds(se1), .o_setting(st1), .o_time_stb(stb1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: index 0 = 24 h instance, 1 = 12 h instance
    int eh[2], em[2], es[2];
    bit eset[2], estb[2];

    function automatic logic [18:0] obs(int k);
        return (k == 0) ? {hr0, mi0, se0, st0, stb0} : {hr1, mi1, se1, st1, stb1};
    endfunction

    function automatic logic [18:0] expv(int k);
        return {5'(eh[k]), 6'(em[k]), 6'(es[k]), eset[k], estb[k]};
    endfunction

    function automatic int hour_up(int k, int h);
        return (k == 0) ? (h + 1) % 24 : (h % 12) + 1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            eh[k] = (k == 0) ? 0 : 12;
            em[k] = 0; es[k] = 0; eset[k] = 1'b0; estb[k] = 1'b0;
        end
    endtask

    // advance one second using time-of-day arithmetic
    task automatic second_up(int k);
        int period, t;
        period = (k == 0) ? 86400 : 43200;
        t = (((k == 0) ? eh[k] : eh[k] % 12) * 3600 + em[k] * 60 + es[k] + 1) % period;
        eh[k] = t / 3600;
        if (k == 1 && eh[k] == 0) eh[k] = 12;
        em[k] = (t / 60) % 60;
        es[k] = t % 60;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                estb[k] = 1'b0;
                if (en) begin
                    if (!eset[k]) begin
                        if (sh || sm) begin
                            eset[k] = 1'b1; es[k] = 0; estb[k] = 1'b1;
                            if (sh) eh[k] = hour_up(k, eh[k]);
                            if (sm) em[k] = (em[k] + 1) % 60;
                        end else if (hz) begin
                            second_up(k); estb[k] = 1'b1;
                        end
                    end else begin
                        if (!(sh || sm)) begin
                            eset[k] = 1'b0;
                        end else if (ts) begin
                            estb[k] = 1'b1;
                            if (sh) eh[k] = hour_up(k, eh[k]);
                            if (sm) em[k] = (em[k] + 1) % 60;
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic preset(int nh, int nm, int nsec);
        if (nh > 0) begin
            sh = 1'b1;
            for (int i = 0; i < nh; i++) begin
                ts = (i != 0);
                tick();
                ts = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_cmp++;
                    if (obs(k) !== expv(k)) begin
                        n_fail++;
                        $display("FAIL preset_hours mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                    end
                end
            end
            sh = 1'b0;
            tick();
        end
        if (nm > 0) begin
            sm = 1'b1;
            for (int i = 0; i < nm; i++) begin
                ts = (i != 0);
                tick();
                ts = 1'b0;
                for (int k = 0; k < 2; k++) begin
                    n_cmp++;
                    if (obs(k) !== expv(k)) begin
                        n_fail++;
                        $display("FAIL preset_minutes mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                    end
                end
            end
            sm = 1'b0;
            tick();
        end
        for (int i = 0; i < nsec; i++) begin
            hz = 1'b1;
            tick();
            hz = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL preset_done mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        model_reset();
        n_cmp++;
        if ({hr0, mi0, se0, st0, stb0} !== {5'd0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset24 got=%0d:%0d:%0d set=%b stb=%b want=0:0:0 0 0", hr0, mi0, se0, st0, stb0);
        end
        n_cmp++;
        if ({hr1, mi1, se1, st1, stb1} !== {5'd12, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset12 got=%0d:%0d:%0d set=%b stb=%b want=12:0:0 0 0", hr1, mi1, se1, st1, stb1);
        end
        en = 1'b1; hz = 1'b1; sh = 1'b1;
        tick();
        tick();
        hz = 1'b0; sh = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL reset_held mode%0d got=%h want=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_seconds();
        int pulses = 0;
        for (int i = 0; i < 61; i++) begin
            hz = 1'b1;
            tick();
            hz = 1'b0;
            if (stb0) pulses++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL seconds_stb mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                end
            end
            tick();
            if (stb0) pulses++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL seconds_idle mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                end
            end
        end
        n_cmp++;
        if ({hr0, mi0, se0} !== {5'd0, 6'd1, 6'd1}) begin
            n_fail++;
            $display("FAIL seconds_61 got=%0d:%0d:%0d want=0:1:1", hr0, mi0, se0);
        end
        n_cmp++;
        if (pulses != 61) begin
            n_fail++;
            $display("FAIL stb_count got=%0d want=61", pulses);
        end
    endtask

    task automatic test_full_carry();
        do_reset();
        preset(23, 59, 59);
        hz = 1'b1;
        tick();
        hz = 1'b0;
        n_cmp++;
        if ({hr0, mi0, se0, stb0} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL carry24 got=%0d:%0d:%0d stb=%b want=0:0:0 1", hr0, mi0, se0, stb0);
        end
        n_cmp++;
        if ({hr1, mi1, se1} !== {5'd12, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL carry12_11to12 got=%0d:%0d:%0d want=12:0:0", hr1, mi1, se1);
        end
        preset(0, 59, 59);
        hz = 1'b1;
        tick();
        hz = 1'b0;
        n_cmp++;
        if ({hr1, mi1, se1} !== {5'd1, 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL carry12 got=%0d:%0d:%0d want=1:0:0", hr1, mi1, se1);
        end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL carry_model mode%0d got=%h want=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_set_minutes();
        do_reset();
        preset(10, 20, 35);
        sm = 1'b1;
        tick();
        n_cmp++;
        if ({hr0, mi0, se0, st0} !== {5'd10, 6'd21, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL setmin_entry got=%0d:%0d:%0d set=%b want=10:21:0 1", hr0, mi0, se0, st0);
        end
        for (int i = 0; i < 40; i++) begin
            ts = 1'b1;
            tick();
            ts = 1'b0;
            hz = 1'b1;
            tick();
            hz = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL setmin_step mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                end
            end
        end
        n_cmp++;
        if ({hr0, mi0, se0, st0} !== {5'd10, 6'd1, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL setmin_wrap got=%0d:%0d:%0d set=%b want=10:1:0 1", hr0, mi0, se0, st0);
        end
        sm = 1'b0;
        hz = 1'b1;
        tick();
        hz = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL setmin_exit mode%0d got=%h want=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_both_buttons();
        do_reset();
        preset(5, 5, 7);
        sh = 1'b1; sm = 1'b1; hz = 1'b1;
        tick();
        hz = 1'b0;
        n_cmp++;
        if ({hr0, mi0, se0, st0, stb0} !== {5'd6, 6'd6, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL both_entry got=%0d:%0d:%0d set=%b stb=%b want=6:6:0 1 1", hr0, mi0, se0, st0, stb0);
        end
        ts = 1'b1;
        tick();
        ts = 1'b0;
        n_cmp++;
        if ({hr0, mi0, se0} !== {5'd7, 6'd7, 6'd0}) begin
            n_fail++;
            $display("FAIL both_step got=%0d:%0d:%0d want=7:7:0", hr0, mi0, se0);
        end
        sh = 1'b0; sm = 1'b0;
        tick();
        n_cmp++;
        if ({st0, st1, stb0} !== 3'b000) begin
            n_fail++;
            $display("FAIL both_exit set=%b%b stb=%b want=00 0", st0, st1, stb0);
        end
        hz = 1'b1;
        tick();
        hz = 1'b0;
        n_cmp++;
        if ({hr0, mi0, se0, stb0} !== {5'd7, 6'd7, 6'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL both_run got=%0d:%0d:%0d stb=%b want=7:7:1 1", hr0, mi0, se0, stb0);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            hz = 1'b1;
            sh = (i == 2);
            ts = (i == 3);
            tick();
            hz = 1'b0; sh = 1'b0; ts = 1'b0;
            tick();
            n_cmp++;
            if ({hr0, mi0, se0, st0, stb0} !== {5'd7, 6'd7, 6'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL enable_frozen got=%0d:%0d:%0d set=%b stb=%b want=7:7:1 0 0", hr0, mi0, se0, st0, stb0);
            end
        end
        en = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL enable_resume mode%0d got=%h want=%h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        preset(13, 33, 0);
        sh = 1'b1;
        tick();
        n_cmp++;
        if ({hr0, mi0, se0, st0} !== {5'd14, 6'd33, 6'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_setup got=%0d:%0d:%0d set=%b want=14:33:0 1", hr0, mi0, se0, st0);
        end
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({hr0, mi0, se0, st0, stb0} !== {5'd0, 6'd0, 6'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL areset_immediate got=%0d:%0d:%0d set=%b stb=%b want=0:0:0 0 0", hr0, mi0, se0, st0, stb0);
        end
        #1;
        rst = 1'b0;
        tick();
        sh = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== expv(k)) begin
                n_fail++;
                $display("FAIL areset_reentry mode%0d got=%h want=%h", k, obs(k), expv(k));
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 15) != 0);
            hz = ($urandom_range(0, 2) == 0);
            ts = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) sh = ~sh;
            if ($urandom_range(0, 39) == 0) sm = ~sm;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== expv(k)) begin
                    n_fail++;
                    $display("FAIL random mode%0d t=%0t got=%h want=%h", k, $time, obs(k), expv(k));
                end
            end
        end
        en = 1'b1; hz = 1'b0; ts = 1'b0; sh = 1'b0; sm = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_seconds();
        test_full_carry();
        test_set_minutes();
        test_both_buttons();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
